// File: rtl/ee354_numlock_pkg.sv
// Shared definitions for the numlock push-button conditioners and the debug display logic.
// State codes are one-hot so each state bit can be tapped directly as a debug output.
package ee354_numlock_pkg;

    localparam int N_DC_SYN = 20;
    localparam int N_DC_SIM = 3;
    localparam int N_DC_DEF = 4;

    localparam int ST_W = 6;

    // INI idle | WQ press qualify | SCEN accept | WH held | MCEN repeat | CCR release qualify
    typedef enum logic [ST_W-1:0] {
        ST_INI  = 6'b000001,
        ST_WQ   = 6'b000010,
        ST_SCEN = 6'b000100,
        ST_WH   = 6'b001000,
        ST_MCEN = 6'b010000,
        ST_CCR  = 6'b100000
    } state_e;

endpackage

// File: rtl/ee354_sync2.sv
// Two-flop synchroniser for an asynchronous level; both flops clear on reset.
module ee354_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ee354_numlock_btn_cond.sv
// Push-button conditioner: synchronise, debounce press and release, and emit one SCEN
// pulse per accepted press plus repeat (MCEN), held (CCEN) and debounced level (DPB).
module ee354_numlock_btn_cond
    import ee354_numlock_pkg::*;
#(
    parameter int N_DC = N_DC_DEF
) (
    input  logic Clk,
    input  logic reset,
    input  logic PB,
    output logic DPB,
    output logic SCEN,
    output logic MCEN,
    output logic CCEN,
    output logic q_INI,
    output logic q_WQ,
    output logic q_SCEN,
    output logic q_WH,
    output logic q_MCEN,
    output logic q_CCR
);

    localparam logic [N_DC-1:0] CNT_MAX = '1;

    logic            pb_s;
    state_e          state_q, state_d;
    logic [N_DC-1:0] cnt_q, cnt_d;

    ee354_sync2 u_sync (
        .clk_i (Clk),
        .rst_i (reset),
        .d_i   (PB),
        .q_o   (pb_s)
    );

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INI;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Level changes win over terminal count, so the counter never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INI: begin
                cnt_d = '0;
                if (pb_s) state_d = ST_WQ;
            end
            ST_WQ: begin
                if (!pb_s) begin
                    state_d = ST_INI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_SCEN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SCEN: begin
                state_d = ST_WH;
                cnt_d   = '0;
            end
            ST_WH: begin
                if (!pb_s) begin
                    state_d = ST_CCR;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_MCEN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MCEN: begin
                state_d = ST_WH;
                cnt_d   = '0;
            end
            ST_CCR: begin
                if (pb_s) begin
                    state_d = ST_WH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_INI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_INI;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        DPB  = 1'b0;
        SCEN = 1'b0;
        MCEN = 1'b0;
        CCEN = 1'b0;
        case (state_q)
            ST_SCEN: begin
                DPB  = 1'b1;
                SCEN = 1'b1;
                MCEN = 1'b1;
                CCEN = 1'b1;
            end
            ST_WH: begin
                DPB  = 1'b1;
                CCEN = 1'b1;
            end
            ST_MCEN: begin
                DPB  = 1'b1;
                MCEN = 1'b1;
                CCEN = 1'b1;
            end
            ST_CCR: begin
                DPB = 1'b1;
            end
            default: begin
                DPB = 1'b0;
            end
        endcase
    end

    assign q_INI  = (state_q == ST_INI);
    assign q_WQ   = (state_q == ST_WQ);
    assign q_SCEN = (state_q == ST_SCEN);
    assign q_WH   = (state_q == ST_WH);
    assign q_MCEN = (state_q == ST_MCEN);
    assign q_CCR  = (state_q == ST_CCR);

endmodule

// File: tb/tb_ee354_numlock_btn_cond.sv
// Directed bench for the push-button conditioner: U instance for single-button scenarios,
// U and Z instances together for the press-sequence scenario.
module tb_ee354_numlock_btn_cond;

    localparam logic [5:0] S_INI  = 6'b000001;
    localparam logic [5:0] S_WQ   = 6'b000010;
    localparam logic [5:0] S_WH   = 6'b001000;
    localparam logic [5:0] S_CCR  = 6'b100000;

    logic Clk, reset, PB_u, PB_z;
    logic DPB_u, SCEN_u, MCEN_u, CCEN_u;
    logic qi_u, qwq_u, qs_u, qwh_u, qm_u, qc_u;
    logic DPB_z, SCEN_z, MCEN_z, CCEN_z;
    logic qi_z, qwq_z, qs_z, qwh_z, qm_z, qc_z;
    logic [3:0] outs_u, outs_z;
    logic [5:0] st_u, st_z;

    int errors = 0;
    int checks = 0;

    assign outs_u = {DPB_u, SCEN_u, MCEN_u, CCEN_u};
    assign outs_z = {DPB_z, SCEN_z, MCEN_z, CCEN_z};
    assign st_u   = {qc_u, qm_u, qwh_u, qs_u, qwq_u, qi_u};
    assign st_z   = {qc_z, qm_z, qwh_z, qs_z, qwq_z, qi_z};

    ee354_numlock_btn_cond #(.N_DC(3)) dut_u (
        .Clk(Clk), .reset(reset), .PB(PB_u),
        .DPB(DPB_u), .SCEN(SCEN_u), .MCEN(MCEN_u), .CCEN(CCEN_u),
        .q_INI(qi_u), .q_WQ(qwq_u), .q_SCEN(qs_u), .q_WH(qwh_u), .q_MCEN(qm_u), .q_CCR(qc_u)
    );

    ee354_numlock_btn_cond #(.N_DC(3)) dut_z (
        .Clk(Clk), .reset(reset), .PB(PB_z),
        .DPB(DPB_z), .SCEN(SCEN_z), .MCEN(MCEN_z), .CCEN(CCEN_z),
        .q_INI(qi_z), .q_WQ(qwq_z), .q_SCEN(qs_z), .q_WH(qwh_z), .q_MCEN(qm_z), .q_CCR(qc_z)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive the button levels for the next edge, then sample 1 ns after it.
    task automatic step(input logic pu, input logic pz);
        PB_u = pu;
        PB_z = pz;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        PB_u  = 1'b0;
        PB_z  = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (st_u !== S_INI) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", st_u, S_INI);
        end
        checks++;
        if ({outs_u, outs_z} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", {outs_u, outs_z}, 8'h00);
        end
        #9 reset = 1'b0;
        for (int e = 1; e <= 5; e++) step(1'b0, 1'b0);
        checks++;
        if ({st_u, st_z} !== {S_INI, S_INI} || {outs_u, outs_z} !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle got=%b/%b exp=%b/0", st_u, outs_u, S_INI);
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] exp;
        logic [5:0] exp_st;
        for (int e = 1; e <= 60; e++) begin
            step(e <= 40, 1'b0);
            exp = {(e >= 11 && e <= 50), (e == 11),
                   (e == 11 || e == 20 || e == 29 || e == 38), (e >= 11 && e <= 42)};
            checks++;
            if (outs_u !== exp) begin
                errors++;
                $display("FAIL clean_press edge=%0d DPB/SCEN/MCEN/CCEN got=%b exp=%b", e, outs_u, exp);
            end
            if (e == 43 || e == 51) begin
                exp_st = (e == 43) ? S_CCR : S_INI;
                checks++;
                if (st_u !== exp_st) begin
                    errors++;
                    $display("FAIL clean_press_state edge=%0d got=%b exp=%b", e, st_u, exp_st);
                end
            end
        end
    endtask

    task automatic test_glitch();
        for (int e = 1; e <= 20; e++) begin
            step(e <= 5, 1'b0);
            checks++;
            if (outs_u !== 4'b0000) begin
                errors++;
                $display("FAIL glitch edge=%0d outputs got=%b exp=0000", e, outs_u);
            end
            if (e == 4 || e == 8) begin
                checks++;
                if (st_u !== ((e == 4) ? S_WQ : S_INI)) begin
                    errors++;
                    $display("FAIL glitch_state edge=%0d got=%b exp=%b", e, st_u,
                             (e == 4) ? S_WQ : S_INI);
                end
            end
        end
    endtask

    task automatic test_bouncy_press();
        logic pb;
        int   nscen;
        nscen = 0;
        for (int e = 1; e <= 45; e++) begin
            pb = (e <= 12) ? (((e - 1) / 2) % 2 == 0) : (e <= 28);
            step(pb, 1'b0);
            if (SCEN_u) nscen++;
            checks++;
            if ({SCEN_u, MCEN_u} !== {(e == 23), (e == 23)}) begin
                errors++;
                $display("FAIL bouncy_press edge=%0d SCEN/MCEN got=%b exp=%b", e,
                         {SCEN_u, MCEN_u}, {(e == 23), (e == 23)});
            end
        end
        checks++;
        if (nscen !== 1 || st_u !== S_INI) begin
            errors++;
            $display("FAIL bouncy_press_count got=%0d/%b exp=1/%b", nscen, st_u, S_INI);
        end
    endtask

    task automatic test_bouncy_release();
        logic       pb;
        logic [3:0] exp;
        logic [5:0] exp_st;
        for (int e = 1; e <= 45; e++) begin
            pb = (e <= 14) || (e >= 18 && e <= 24);
            step(pb, 1'b0);
            exp = {(e >= 11 && e <= 34), (e == 11), (e == 11),
                   ((e >= 11 && e <= 16) || (e >= 20 && e <= 26))};
            checks++;
            if (outs_u !== exp) begin
                errors++;
                $display("FAIL bouncy_release edge=%0d DPB/SCEN/MCEN/CCEN got=%b exp=%b", e, outs_u, exp);
            end
            if (e == 17 || e == 20 || e == 27 || e == 35) begin
                exp_st = (e == 20) ? S_WH : ((e == 35) ? S_INI : S_CCR);
                checks++;
                if (st_u !== exp_st) begin
                    errors++;
                    $display("FAIL bouncy_release_state edge=%0d got=%b exp=%b", e, st_u, exp_st);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int ph = 0; ph < 2; ph++) begin
            for (int e = 1; e <= ((ph == 0) ? 5 : 3); e++) step(1'b1, 1'b0);
            checks++;
            if (st_u !== ((ph == 0) ? S_WQ : S_WH)) begin
                errors++;
                $display("FAIL reset_mid_pre phase=%0d got=%b exp=%b", ph, st_u,
                         (ph == 0) ? S_WQ : S_WH);
            end
            reset = 1'b1;
            #4;
            checks++;
            if (st_u !== S_INI || outs_u !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_async phase=%0d got=%b/%b exp=%b/0000", ph, st_u, outs_u, S_INI);
            end
            #5 reset = 1'b0;
            for (int e = 1; e <= 12; e++) begin
                step(1'b1, 1'b0);
                checks++;
                if (SCEN_u !== (e == 11)) begin
                    errors++;
                    $display("FAIL reset_mid_requalify phase=%0d edge=%0d SCEN got=%b exp=%b",
                             ph, e, SCEN_u, (e == 11));
                end
            end
        end
        for (int e = 1; e <= 15; e++) step(1'b0, 1'b0);
        checks++;
        if (st_u !== S_INI || DPB_u !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release got=%b/%b exp=%b/0", st_u, DPB_u, S_INI);
        end
    endtask

    task automatic test_back_to_back();
        int   ev_t[$];
        logic ev_w[$];
        int   exp_t[4];
        logic [3:0] exp_w;
        logic pu, pz;
        exp_t = '{11, 41, 71, 101};
        exp_w = 4'b0010;
        for (int e = 1; e <= 125; e++) begin
            pu = (e <= 15) || (e >= 61 && e <= 75) || (e >= 91 && e <= 105);
            pz = (e >= 31 && e <= 45);
            step(pu, pz);
            if (SCEN_u) begin
                ev_t.push_back(e);
                ev_w.push_back(1'b0);
            end
            if (SCEN_z) begin
                ev_t.push_back(e);
                ev_w.push_back(1'b1);
            end
        end
        checks++;
        if (ev_t.size() !== 4) begin
            errors++;
            $display("FAIL back_to_back_count got=%0d exp=4", ev_t.size());
        end
        for (int i = 0; i < 4 && i < ev_t.size(); i++) begin
            checks++;
            if (ev_t[i] !== exp_t[i] || ev_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL back_to_back_symbol idx=%0d got=edge%0d/btn%0d exp=edge%0d/btn%0d",
                         i, ev_t[i], ev_w[i], exp_t[i], exp_w[i]);
            end
        end
        checks++;
        if ({st_u, st_z} !== {S_INI, S_INI}) begin
            errors++;
            $display("FAIL back_to_back_idle got=%b/%b exp=%b/%b", st_u, st_z, S_INI, S_INI);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bouncy_press();
        test_bouncy_release();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
